// File: rtl/seg7_scan_decoder.sv
// Monitor for a multiplexed 4-digit 7-segment bus: filters scan glitches and rebuilds the hex value on display.
// Optional decimal-point capture (dp_mask output) is enabled by defining SEG7_DP_CAPTURE_EN.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodes,
  input  logic [7:0]  cathodes,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        err_pattern,
  output logic        err_collision,
  output logic        stale
`ifdef SEG7_DP_CAPTURE_EN
  ,
  output logic [3:0]  dp_mask
`endif
);

  localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
`ifdef SEG7_DP_CAPTURE_EN
  localparam logic [7:0]  CAT_MASK   = 8'hFF;
`else
  localparam logic [7:0]  CAT_MASK   = 8'h7F;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nib;
  } glyph_t;

  function automatic glyph_t decode_glyph(input logic [6:0] seg);
    glyph_t g;
    g = '{legal: 1'b1, blank: 1'b0, nib: 4'h0};
    case (seg)
      7'h40: g.nib = 4'h0;
      7'h79: g.nib = 4'h1;
      7'h24: g.nib = 4'h2;
      7'h30: g.nib = 4'h3;
      7'h19: g.nib = 4'h4;
      7'h12: g.nib = 4'h5;
      7'h02: g.nib = 4'h6;
      7'h78: g.nib = 4'h7;
      7'h00: g.nib = 4'h8;
      7'h10: g.nib = 4'h9;
      7'h08: g.nib = 4'hA;
      7'h03: g.nib = 4'hB;
      7'h46: g.nib = 4'hC;
      7'h21: g.nib = 4'hD;
      7'h06: g.nib = 4'hE;
      7'h0E: g.nib = 4'hF;
      7'h7F: begin g.legal = 1'b0; g.blank = 1'b1; end
      default: g.legal = 1'b0;
    endcase
    return g;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] an);
    case (an)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Synchronizer stages; s2 is the working sample, s3 the previous one for change detection.
  logic [3:0] an_s1_q, an_s2_q, an_s3_q;
  logic [7:0] cat_s1_q, cat_s2_q, cat_s3_q;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values, like real hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_s1_q  <= 4'hF;
      an_s2_q  <= 4'hF;
      an_s3_q  <= 4'hF;
      cat_s1_q <= 8'hFF;
      cat_s2_q <= 8'hFF;
      cat_s3_q <= 8'hFF;
    end else begin
      an_s1_q  <= anodes;
      an_s2_q  <= an_s1_q;
      an_s3_q  <= an_s2_q;
      cat_s1_q <= cathodes;
      cat_s2_q <= cat_s1_q;
      cat_s3_q <= cat_s2_q;
    end
  end

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [3:0][3:0] shadow_val_q, shadow_val_d;
  logic [3:0]      shadow_blank_q, shadow_blank_d;
  logic [3:0]      got_q, got_d;
  logic [15:0]     value_q, value_d;
  logic [3:0]      blank_q, blank_d;
  logic            fv_q, fv_d;
  logic            ep_q, ep_d;
  logic            ec_q, ec_d;
  logic            stale_q, stale_d;
`ifdef SEG7_DP_CAPTURE_EN
  logic [3:0]      shadow_dp_q, shadow_dp_d;
  logic [3:0]      dp_q, dp_d;
`endif

  logic       idle_now, onehot_now, coll_now, coll_prev, changed, advance, capture, frame_done;
  logic [7:0] cnt_n;
  logic [1:0] idx;
  glyph_t     glyph;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    idle_now   = (an_s2_q == 4'hF);
    onehot_now = an_s2_q inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    coll_now   = !idle_now && !onehot_now;
    coll_prev  = (an_s3_q != 4'hF) &&
                 !(an_s3_q inside {4'b1110, 4'b1101, 4'b1011, 4'b0111});
    changed    = (an_s2_q != an_s3_q) || (((cat_s2_q ^ cat_s3_q) & CAT_MASK) != 8'h00);
    idx        = low_index(an_s2_q);
    glyph      = decode_glyph(cat_s2_q[6:0]);
    frame_done = (got_q == 4'hF);

    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_n   = 8'd1;
    advance = 1'b0;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (onehot_now) advance = 1'b1;
      end
      SETTLE: begin
        if (!onehot_now) begin
          state_d = IDLE;
        end else begin
          advance = 1'b1;
          if (!changed) cnt_n = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (changed) begin
          if (onehot_now) advance = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      cnt_d = cnt_n;
      if (cnt_n == SETTLE_MAX) begin
        capture = 1'b1;
        state_d = HELD;
      end else begin
        state_d = SETTLE;
      end
    end

    shadow_val_d   = shadow_val_q;
    shadow_blank_d = shadow_blank_q;
    got_d          = frame_done ? 4'h0 : got_q;
    if (capture && (glyph.legal || glyph.blank)) begin
      shadow_val_d[idx]   = glyph.blank ? 4'h0 : glyph.nib;
      shadow_blank_d[idx] = glyph.blank;
      got_d[idx]          = 1'b1;
    end

    value_d = frame_done ? shadow_val_q   : value_q;
    blank_d = frame_done ? shadow_blank_q : blank_q;
    fv_d    = frame_done;
    ep_d    = capture && !glyph.legal && !glyph.blank;
    ec_d    = coll_now && !coll_prev;

    if (frame_done)          tcnt_d = '0;
    else if (tcnt_q == TMAX) tcnt_d = tcnt_q;
    else                     tcnt_d = tcnt_q + TW'(1);
    stale_d = (tcnt_d == TMAX);

`ifdef SEG7_DP_CAPTURE_EN
    shadow_dp_d = shadow_dp_q;
    if (capture && (glyph.legal || glyph.blank)) shadow_dp_d[idx] = ~cat_s2_q[7];
    dp_d = frame_done ? shadow_dp_q : dp_q;
`endif
  end

  // NOTE: shadow registers are reset along with control state so a reset mid-frame cannot leak old digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tcnt_q         <= '0;
      shadow_val_q   <= '0;
      shadow_blank_q <= '0;
      got_q          <= '0;
      value_q        <= '0;
      blank_q        <= '0;
      fv_q           <= 1'b0;
      ep_q           <= 1'b0;
      ec_q           <= 1'b0;
      stale_q        <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      shadow_dp_q    <= '0;
      dp_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tcnt_q         <= tcnt_d;
      shadow_val_q   <= shadow_val_d;
      shadow_blank_q <= shadow_blank_d;
      got_q          <= got_d;
      value_q        <= value_d;
      blank_q        <= blank_d;
      fv_q           <= fv_d;
      ep_q           <= ep_d;
      ec_q           <= ec_d;
      stale_q        <= stale_d;
`ifdef SEG7_DP_CAPTURE_EN
      shadow_dp_q    <= shadow_dp_d;
      dp_q           <= dp_d;
`endif
    end
  end

  assign value         = value_q;
  assign blank_mask    = blank_q;
  assign frame_valid   = fv_q;
  assign err_pattern   = ep_q;
  assign err_collision = ec_q;
  assign stale         = stale_q;
`ifdef SEG7_DP_CAPTURE_EN
  assign dp_mask       = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: table of 4-digit scans plus hand-written
// sequences for glitch, collision, timeout and mid-capture reset; frames checked via a scoreboard queue.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        frame_valid, err_pattern, err_collision, stale;
`ifdef SEG7_DP_CAPTURE_EN
  logic [3:0]  dp_mask;
`endif

  seg7_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk           (clk),
    .reset         (reset),
    .anodes        (anodes),
    .cathodes      (cathodes),
    .value         (value),
    .blank_mask    (blank_mask),
    .frame_valid   (frame_valid),
    .err_pattern   (err_pattern),
    .err_collision (err_collision),
    .stale         (stale)
`ifdef SEG7_DP_CAPTURE_EN
    ,
    .dp_mask       (dp_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  blank;
  } frame_t;

  typedef struct {
    logic [7:0]  cat [4];
    int          hold;
    int          exp_frames;
    logic [15:0] exp_value;
    logic [3:0]  exp_blank;
    int          exp_pat;
  } vec_t;

  frame_t exp_q[$];
  frame_t mon_f;
  int     checks = 0, failures = 0;
  int     fv_cnt = 0, pat_cnt = 0, col_cnt = 0;
  logic   fv_stale = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: samples 1 ns after each rising edge and pops the scoreboard on frame_valid.
  always @(posedge clk) begin
    #1;
    if (err_pattern)   pat_cnt++;
    if (err_collision) col_cnt++;
    if (frame_valid) begin
      fv_cnt++;
      fv_stale = stale;
      check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        mon_f = exp_q.pop_front();
        check("frame_value", 32'(value), 32'(mon_f.value));
        check("frame_blank", 32'(blank_mask), 32'(mon_f.blank));
      end
    end
  end

  task automatic idle(input int n);
    anodes   = 4'hF;
    cathodes = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_digit(input int i, input logic [7:0] c, input int n);
    logic [3:0] a;
    a        = 4'hF;
    a[i]     = 1'b0;
    anodes   = a;
    cathodes = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] b);
    frame_t f;
    f.value = v;
    f.blank = b;
    exp_q.push_back(f);
  endtask

  function automatic vec_t mk(input logic [7:0] c0, c1, c2, c3, input int ef,
                              input logic [15:0] v, input logic [3:0] b, input int p);
    vec_t r;
    r.cat        = '{c0, c1, c2, c3};
    r.hold       = 10;
    r.exp_frames = ef;
    r.exp_value  = v;
    r.exp_blank  = b;
    r.exp_pat    = p;
    return r;
  endfunction

  vec_t vecs [8];

  initial begin
    int f0, p0, c0;

    vecs[0] = mk(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1, 16'h3210, 4'b0000, 0);
    vecs[1] = mk(8'hC0, 8'hF9, 8'hFF, 8'hB0, 1, 16'h3010, 4'b0100, 0);
    vecs[2] = mk(8'h81, 8'hF9, 8'hA4, 8'hB0, 0, 16'h0000, 4'b0000, 1);
    vecs[3] = mk(8'h88, 8'h83, 8'hC6, 8'hA1, 1, 16'hDCBA, 4'b0000, 0);
    vecs[4] = mk(8'h86, 8'h8E, 8'h80, 8'h90, 1, 16'h98FE, 4'b0000, 0);
    vecs[5] = mk(8'h99, 8'h92, 8'h82, 8'hF8, 1, 16'h7654, 4'b0000, 0);
    vecs[6] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 16'h0000, 4'b1111, 0);
    vecs[7] = mk(8'h40, 8'h79, 8'h24, 8'h30, 1, 16'h3210, 4'b0000, 0);

    reset    = 1'b1;
    anodes   = 4'hF;
    cathodes = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_value", 32'(value), 32'h0);
    check("rst_blank", 32'(blank_mask), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_err_pattern", 32'(err_pattern), 32'h0);
    check("rst_err_collision", 32'(err_collision), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      idle(2);
      f0 = fv_cnt; p0 = pat_cnt; c0 = col_cnt;
      if (vecs[v].exp_frames != 0) push_frame(vecs[v].exp_value, vecs[v].exp_blank);
      for (int d = 0; d < 4; d++) scan_digit(d, vecs[v].cat[d], vecs[v].hold);
      idle(8);
      check($sformatf("vec%0d_frames", v), 32'(fv_cnt - f0), 32'(vecs[v].exp_frames));
      check($sformatf("vec%0d_err_pattern", v), 32'(pat_cnt - p0), 32'(vecs[v].exp_pat));
      check($sformatf("vec%0d_err_collision", v), 32'(col_cnt - c0), 32'd0);
    end

    // Digit 1 shown too briefly to settle; frame completes only after a proper rescan.
    do_reset();
    idle(2);
    f0 = fv_cnt;
    scan_digit(0, 8'hC0, 10);
    scan_digit(1, 8'hF9, 3);
    scan_digit(2, 8'hA4, 10);
    scan_digit(3, 8'hB0, 10);
    idle(8);
    check("glitch_no_frame", 32'(fv_cnt - f0), 32'd0);
    push_frame(16'h3210, 4'b0000);
    scan_digit(1, 8'hF9, 10);
    idle(8);
    check("glitch_rescan_frame", 32'(fv_cnt - f0), 32'd1);

    // Collision held 5 cycles: one pulse, partial frame survives.
    do_reset();
    idle(2);
    f0 = fv_cnt; c0 = col_cnt;
    scan_digit(0, 8'hC0, 10);
    scan_digit(1, 8'hF9, 10);
    scan_digit(2, 8'hA4, 10);
    anodes   = 4'b1100;
    cathodes = 8'hFF;
    repeat (5) @(negedge clk);
    idle(4);
    check("coll_pulses", 32'(col_cnt - c0), 32'd1);
    check("coll_no_frame", 32'(fv_cnt - f0), 32'd0);
    push_frame(16'h3210, 4'b0000);
    scan_digit(3, 8'hB0, 10);
    idle(8);
    check("coll_got_kept_frame", 32'(fv_cnt - f0), 32'd1);
    check("coll_pulses_after", 32'(col_cnt - c0), 32'd1);

    // Timeout: stale rises exactly 50 cycles after reset, drops with frame_valid.
    do_reset();
    repeat (49) @(posedge clk);
    #1;
    check("stale_before_50", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    check("stale_at_50", 32'(stale), 32'd1);
    @(negedge clk);
    f0 = fv_cnt;
    fv_stale = 1'b1;
    push_frame(16'h3210, 4'b0000);
    scan_digit(0, 8'hC0, 10);
    scan_digit(1, 8'hF9, 10);
    scan_digit(2, 8'hA4, 10);
    check("stale_during_scan", 32'(stale), 32'd1);
    scan_digit(3, 8'hB0, 10);
    idle(8);
    check("timeout_frame", 32'(fv_cnt - f0), 32'd1);
    check("stale_at_frame_valid", 32'(fv_stale), 32'd0);
    check("stale_after_frame", 32'(stale), 32'd0);

    // Reset while digit 1 is settling: outputs clear next edge, got is cleared.
    do_reset();
    idle(2);
    push_frame(16'h3210, 4'b0000);
    scan_digit(0, 8'hC0, 10);
    scan_digit(1, 8'hF9, 10);
    scan_digit(2, 8'hA4, 10);
    scan_digit(3, 8'hB0, 10);
    idle(8);
    check("pre_reset_value", 32'(value), 32'h3210);
    scan_digit(0, 8'h99, 10);
    scan_digit(1, 8'hF9, 4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_blank", 32'(blank_mask), 32'h0);
    check("midrst_frame_valid", 32'(frame_valid), 32'h0);
    check("midrst_err_pattern", 32'(err_pattern), 32'h0);
    check("midrst_err_collision", 32'(err_collision), 32'h0);
    check("midrst_stale", 32'(stale), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    f0 = fv_cnt;
    scan_digit(1, 8'hF9, 10);
    scan_digit(2, 8'hA4, 10);
    scan_digit(3, 8'hB0, 10);
    idle(8);
    check("midrst_got_cleared", 32'(fv_cnt - f0), 32'd0);
    push_frame(16'h3219, 4'b0000);
    scan_digit(0, 8'h90, 10);
    idle(8);
    check("midrst_refill_frame", 32'(fv_cnt - f0), 32'd1);

    check("sb_final_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
